// File: rtl/osborne_video_if.sv
// Memory fetch ports and pixel/sync outputs of the Osborne character video generator.
// The master drives addresses and video; the slave returns 1-clk-latency RAM/ROM data.
interface osborne_video_if;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic [10:0] crom_addr;
    logic [7:0]  crom_data;
    logic        ce_pix;
    logic        HBlank;
    logic        HSync;
    logic        VBlank;
    logic        VSync;
    logic [7:0]  video;

    modport master (
        output vram_addr, crom_addr, ce_pix, HBlank, HSync, VBlank, VSync, video,
        input  vram_data, crom_data
    );

    modport slave (
        input  vram_addr, crom_addr, ce_pix, HBlank, HSync, VBlank, VSync, video,
        output vram_data, crom_data
    );
endinterface

// File: rtl/osborne_video.sv
// 52x24 character video with scroll; fetches one char ahead (4 clk RAM->ROM->hold pipeline).
// Free-running raster: no backpressure, outputs update on the pixel enable only.
module osborne_video #(
    parameter int CE_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pal,
    input  logic [6:0] hscroll,
    input  logic [4:0] vscroll,
    osborne_video_if.master vif
);
    localparam logic [3:0] CE_LAST     = 4'(CE_DIV - 1);
    localparam logic [8:0] H_ACT       = 9'd416;
    localparam logic [8:0] HS_ON       = 9'd440;
    localparam logic [8:0] HS_OFF      = 9'd480;
    localparam logic [8:0] H_LINE_FET  = 9'd508;
    localparam logic [8:0] V_ACT       = 9'd240;
    localparam logic [8:0] V_LAST_NTSC = 9'd261;
    localparam logic [8:0] V_LAST_PAL  = 9'd311;
    localparam logic [8:0] VS_NTSC     = 9'd248;
    localparam logic [8:0] VS_PAL      = 9'd272;

    logic [3:0]  r_ce_cnt;
    logic        r_ce;
    logic        r_ce_pix;
    logic [8:0]  r_hcnt;
    logic [8:0]  r_vcnt;
    logic [4:0]  r_row;
    logic [3:0]  r_scan;
    logic        r_lat_vld;
    logic        r_pal;
    logic [6:0]  r_hscroll;
    logic [4:0]  r_vscroll;
    logic [3:0]  r_stg;
    logic [3:0]  r_fscan;
    logic        r_inv;
    logic [7:0]  r_hold;
    logic [7:0]  r_shift;
    logic [11:0] r_vram_addr;
    logic [10:0] r_crom_addr;
    logic        r_hblank;
    logic        r_hsync;
    logic        r_vblank;
    logic        r_vsync;
    logic [7:0]  r_video;

    logic        w_pal;
    logic [6:0]  w_hs;
    logic [4:0]  w_vs;
    logic        w_hwrap;
    logic        w_vlast;
    logic        w_frame_start;
    logic [8:0]  w_h_nxt;
    logic [8:0]  w_v_nxt;
    logic [4:0]  w_row_nl;
    logic [3:0]  w_scan_nl;
    logic        w_fetch;
    logic        w_line_fet;
    logic [5:0]  w_fcol;
    logic [4:0]  w_frow;
    logic [3:0]  w_fscan;
    logic [6:0]  w_fhs;
    logic [4:0]  w_fvs;
    logic [4:0]  w_row_eff;
    logic [6:0]  w_col_eff;
    logic [7:0]  w_glyph;
    logic [7:0]  w_shift_nxt;
    logic [8:0]  w_vs_start;

    // Until the first post-reset clock the frame settings follow the ports directly.
    assign w_pal = r_lat_vld ? r_pal     : pal;
    assign w_hs  = r_lat_vld ? r_hscroll : hscroll;
    assign w_vs  = r_lat_vld ? r_vscroll : vscroll;

    assign w_hwrap       = (r_hcnt == 9'd511);
    assign w_vlast       = (r_vcnt == (w_pal ? V_LAST_PAL : V_LAST_NTSC));
    assign w_frame_start = r_ce && w_hwrap && w_vlast;
    assign w_h_nxt       = r_hcnt + 9'd1;
    assign w_v_nxt       = !w_hwrap ? r_vcnt : (w_vlast ? 9'd0 : r_vcnt + 9'd1);
    assign w_vs_start    = w_pal ? VS_PAL : VS_NTSC;

    always_comb begin
        w_row_nl  = r_row;
        w_scan_nl = r_scan + 4'd1;
        if (w_vlast) begin
            w_row_nl  = 5'd0;
            w_scan_nl = 4'd0;
        end else if (r_scan == 4'd9) begin
            w_row_nl  = r_row + 5'd1;
            w_scan_nl = 4'd0;
        end
    end

    assign w_fetch    = r_ce && (w_h_nxt[2:0] == 3'd4);
    assign w_line_fet = (w_h_nxt == H_LINE_FET);
    assign w_fcol     = w_line_fet ? 6'd0 : w_h_nxt[8:3] + 6'd1;
    assign w_frow     = w_line_fet ? w_row_nl : r_row;
    assign w_fscan    = w_line_fet ? w_scan_nl : r_scan;
    // The first fetch of a frame uses the scroll values about to be latched at the wrap.
    assign w_fhs      = (w_line_fet && w_vlast) ? hscroll : w_hs;
    assign w_fvs      = (w_line_fet && w_vlast) ? vscroll : w_vs;
    assign w_row_eff  = w_frow + w_fvs;
    assign w_col_eff  = {1'b0, w_fcol} + w_fhs;

    assign w_glyph     = vif.crom_data ^ {8{r_inv}};
    assign w_shift_nxt = (w_h_nxt[2:0] == 3'd0) ? (r_stg[3] ? w_glyph : r_hold)
                                                 : {r_shift[6:0], 1'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ce_cnt <= 4'd0;
            r_ce     <= 1'b0;
            r_ce_pix <= 1'b0;
        end else begin
            r_ce     <= (r_ce_cnt == CE_LAST);
            r_ce_cnt <= (r_ce_cnt == CE_LAST) ? 4'd0 : r_ce_cnt + 4'd1;
            r_ce_pix <= r_ce;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_lat_vld <= 1'b0;
        else          r_lat_vld <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!r_lat_vld || w_frame_start) begin
            r_pal     <= pal;
            r_hscroll <= hscroll;
            r_vscroll <= vscroll;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt   <= 9'd0;
            r_vcnt   <= 9'd0;
            r_row    <= 5'd0;
            r_scan   <= 4'd0;
            r_shift  <= 8'd0;
            r_hblank <= 1'b1;
            r_hsync  <= 1'b0;
            r_vblank <= 1'b1;
            r_vsync  <= 1'b0;
            r_video  <= 8'd0;
        end else if (r_ce) begin
            r_hcnt   <= w_h_nxt;
            r_vcnt   <= w_v_nxt;
            if (w_hwrap) begin
                r_row  <= w_row_nl;
                r_scan <= w_scan_nl;
            end
            r_shift  <= w_shift_nxt;
            r_hblank <= (w_h_nxt >= H_ACT);
            r_hsync  <= (w_h_nxt >= HS_ON) && (w_h_nxt < HS_OFF);
            r_vblank <= (w_v_nxt >= V_ACT);
            r_vsync  <= (w_v_nxt >= w_vs_start) && (w_v_nxt < w_vs_start + 9'd3);
            r_video  <= (w_shift_nxt[7] && (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT)) ? 8'hFF : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stg       <= 4'd0;
            r_vram_addr <= 12'd0;
            r_fscan     <= 4'd0;
            r_inv       <= 1'b0;
            r_crom_addr <= 11'd0;
            r_hold      <= 8'd0;
        end else begin
            r_stg <= {r_stg[2:0], w_fetch};
            if (w_fetch) begin
                r_vram_addr <= {w_row_eff, w_col_eff};
                r_fscan     <= w_fscan;
            end
            if (r_stg[1]) begin
                r_inv       <= vif.vram_data[7];
                r_crom_addr <= {vif.vram_data[6:0], r_fscan};
            end
            if (r_stg[3]) r_hold <= w_glyph;
        end
    end

    assign vif.vram_addr = r_vram_addr;
    assign vif.crom_addr = r_crom_addr;
    assign vif.ce_pix    = r_ce_pix;
    assign vif.HBlank    = r_hblank;
    assign vif.HSync     = r_hsync;
    assign vif.VBlank    = r_vblank;
    assign vif.VSync     = r_vsync;
    assign vif.video     = r_video;
endmodule
